p88_loader: RTL and testbench

P88_LOADER -- requirements
Module: p88_loader

---
 rtl/p88_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_p88_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p88_loader.sv
// P88 image loader: parses the 8-byte header and streams the payload into system RAM.
// Optional payload checksum byte is enabled by defining P88_CHECKSUM_EN.
module p88_loader #(
  parameter int unsigned INDEX  = 4,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wr,
  input  logic              mem_ack,
  output logic              cpu_hold,
  output logic [15:0]       entry_cs,
  output logic [15:0]       entry_ip,
  output logic              entry_valid,
  output logic              load_err
);

  localparam logic [5:0] L_INDEX = 6'(INDEX);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

  state_t            r_state, w_state;
  logic [15:0]       r_seg, w_seg, r_ip, w_ip, r_cs, w_cs, r_len, w_len, r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [7:0]        r_mem_data, w_mem_data;
  logic              r_mem_wr, w_mem_wr, r_wait, w_wait, r_hold, w_hold;
  logic [15:0]       r_ecs, w_ecs, r_eip, w_eip;
  logic              r_evalid, w_evalid, r_err, w_err, r_lost, w_lost, r_dl_q;
`ifdef P88_CHECKSUM_EN
  logic [7:0]        r_sum, w_sum;
  logic              w_chk_ok;
`endif

  logic        w_start, w_accept, w_payload;
  logic [26:0] w_off;
  logic [31:0] w_addr_full;
  logic [15:0] w_len_hdr, w_cnt_inc;
  logic        w_unused;

  assign w_start     = ioctl_download && (ioctl_index[5:0] == L_INDEX);
  // From ERR, only a fresh rising edge of the download starts a new load.
  assign w_accept    = w_start && ((r_state == S_IDLE) || ((r_state == S_ERR) && !r_dl_q));
  assign w_payload   = (ioctl_addr >= 27'd8);
  assign w_off       = ioctl_addr - 27'd8;
  assign w_addr_full = {12'd0, r_seg, 4'd0} + {5'd0, w_off};
  assign w_len_hdr   = {ioctl_dout, r_len[7:0]};
  assign w_cnt_inc   = r_cnt + 16'd1;
  assign w_unused    = &{1'b0, ioctl_index[15:6], w_addr_full};
`ifdef P88_CHECKSUM_EN
  assign w_chk_ok    = (8'(r_sum + ioctl_dout) == 8'd0);
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_seg      <= '0;
      r_ip       <= '0;
      r_cs       <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_wr   <= 1'b0;
      r_wait     <= 1'b0;
      r_hold     <= 1'b0;
      r_ecs      <= '0;
      r_eip      <= '0;
      r_evalid   <= 1'b0;
      r_err      <= 1'b0;
      r_lost     <= 1'b0;
      r_dl_q     <= 1'b0;
`ifdef P88_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_seg      <= w_seg;
      r_ip       <= w_ip;
      r_cs       <= w_cs;
      r_len      <= w_len;
      r_cnt      <= w_cnt;
      r_mem_addr <= w_mem_addr;
      r_mem_data <= w_mem_data;
      r_mem_wr   <= w_mem_wr;
      r_wait     <= w_wait;
      r_hold     <= w_hold;
      r_ecs      <= w_ecs;
      r_eip      <= w_eip;
      r_evalid   <= w_evalid;
      r_err      <= w_err;
      r_lost     <= w_lost;
      r_dl_q     <= ioctl_download;
`ifdef P88_CHECKSUM_EN
      r_sum      <= w_sum;
`endif
    end
  end

  always_comb begin
    w_state    = r_state;
    w_seg      = r_seg;
    w_ip       = r_ip;
    w_cs       = r_cs;
    w_len      = r_len;
    w_cnt      = r_cnt;
    w_mem_addr = r_mem_addr;
    w_mem_data = r_mem_data;
    w_mem_wr   = r_mem_wr;
    w_wait     = r_wait;
    w_hold     = r_hold;
    w_ecs      = r_ecs;
    w_eip      = r_eip;
    w_evalid   = 1'b0;
    w_err      = r_err;
    w_lost     = r_lost;
`ifdef P88_CHECKSUM_EN
    w_sum      = r_sum;
`endif
    unique case (r_state)
      S_IDLE, S_ERR: begin
        if (w_accept) begin
          w_state = S_HDR;
          w_hold  = 1'b1;
          w_err   = 1'b0;
          w_cnt   = '0;
`ifdef P88_CHECKSUM_EN
          w_sum   = '0;
`endif
        end
      end
      S_HDR: begin
        if (!ioctl_download) begin
          w_state = S_ERR;
          w_err   = 1'b1;
        end else if (ioctl_wr) begin
          unique case (ioctl_addr[2:0])
            3'd0: w_seg[7:0]  = ioctl_dout;
            3'd1: w_seg[15:8] = ioctl_dout;
            3'd2: w_ip[7:0]   = ioctl_dout;
            3'd3: w_ip[15:8]  = ioctl_dout;
            3'd4: w_cs[7:0]   = ioctl_dout;
            3'd5: w_cs[15:8]  = ioctl_dout;
            3'd6: w_len[7:0]  = ioctl_dout;
            default: begin
              w_len = w_len_hdr;
`ifdef P88_CHECKSUM_EN
              w_state = S_DATA;
`else
              w_state = (w_len_hdr == 16'd0) ? S_DONE : S_DATA;
`endif
            end
          endcase
        end
      end
      S_DATA: begin
        if (!ioctl_download) begin
          w_state = S_ERR;
          w_err   = 1'b1;
        end else if (ioctl_wr && w_payload) begin
          if (r_cnt != r_len) begin
            w_mem_addr = w_addr_full[ADDR_W-1:0];
            w_mem_data = ioctl_dout;
            w_mem_wr   = 1'b1;
            w_wait     = 1'b1;
            w_lost     = 1'b0;
            w_state    = S_WRITE;
`ifdef P88_CHECKSUM_EN
            w_sum      = r_sum + ioctl_dout;
`endif
          end
`ifdef P88_CHECKSUM_EN
          else if (w_chk_ok) begin
            w_state = S_DONE;
          end else begin
            w_state = S_ERR;
            w_err   = 1'b1;
          end
`endif
        end
      end
      S_WRITE: begin
        // A download drop here is remembered and acted on once the write is acked.
        if (!ioctl_download) w_lost = 1'b1;
        if (mem_ack) begin
          w_mem_wr = 1'b0;
          w_wait   = 1'b0;
          w_cnt    = w_cnt_inc;
          w_lost   = 1'b0;
          if (r_lost || !ioctl_download) begin
            w_state = S_ERR;
            w_err   = 1'b1;
          end
`ifdef P88_CHECKSUM_EN
          else w_state = S_DATA;
`else
          else if (w_cnt_inc == r_len) w_state = S_DONE;
          else w_state = S_DATA;
`endif
        end
      end
      S_DONE: begin
        if (!ioctl_download) begin
          w_ecs    = r_cs;
          w_eip    = r_ip;
          w_evalid = 1'b1;
          w_hold   = 1'b0;
          w_state  = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign ioctl_wait  = r_wait;
  assign mem_addr    = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign mem_wr      = r_mem_wr;
  assign cpu_hold    = r_hold;
  assign entry_cs    = r_ecs;
  assign entry_ip    = r_eip;
  assign entry_valid = r_evalid;
  assign load_err    = r_err;

endmodule

// File: tb/tb_p88_loader.sv
// Randomized bench for p88_loader: a file-level model predicts writes, entry vector and error outcome.
module tb_p88_loader;

`ifdef P88_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk_sys, reset_n, ioctl_download, ioctl_wr, ioctl_wait;
  logic [15:0] ioctl_index;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_dout, mem_data;
  logic [19:0] mem_addr;
  logic        mem_wr, mem_ack, cpu_hold, entry_valid, load_err;
  logic [15:0] entry_cs, entry_ip;

  p88_loader #(.INDEX(4), .ADDR_W(20)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack), .cpu_hold(cpu_hold),
    .entry_cs(entry_cs), .entry_ip(entry_ip), .entry_valid(entry_valid), .load_err(load_err)
  );

  int n_chk = 0;
  int n_err = 0;
  int ack_delay = 1;
  int waitbad, unstable, dupbad, vcount, vprev, vhold;
  logic [15:0] vcs, vip;
  logic [19:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          wq_cyc[$];
  logic [7:0]  pay[$];

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM responder: acks after ack_delay cycles of mem_wr and logs each accepted write.
  initial begin
    bit busy = 1'b0;
    int cyc = 0;
    logic [19:0] la;
    logic [7:0]  ld;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ioctl_wait !== mem_wr) waitbad++;
      if (mem_ack) begin
        mem_ack = 1'b0;
        busy = 1'b0;
        if (mem_wr) dupbad++;
      end else if (mem_wr) begin
        if (!busy) begin
          busy = 1'b1; cyc = 0; la = mem_addr; ld = mem_data;
        end else if (mem_addr !== la || mem_data !== ld) unstable++;
        cyc++;
        if (cyc >= ack_delay) begin
          mem_ack = 1'b1;
          wq_addr.push_back(la); wq_data.push_back(ld); wq_cyc.push_back(cyc);
        end
      end else busy = 1'b0;
    end
  end

  initial begin
    int prev = 0;
    forever begin
      @(negedge clk_sys);
      if (entry_valid) begin
        vcount++; vcs = entry_cs; vip = entry_ip; vhold = cpu_hold; vprev = prev;
      end
      prev = cpu_hold;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ioctl_wait && n < 2000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (ioctl_wait) chk("wait_timeout", 32'(ioctl_wait), 0);
  endtask

  task automatic strobe(input int a, input logic [7:0] d);
    ioctl_addr = 27'(a); ioctl_dout = d; ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic send_byte(input int a, input logic [7:0] d);
    strobe(a, d);
    @(posedge clk_sys); #1;
    wait_ready();
  endtask

  task automatic clear_logs();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    waitbad = 0; unstable = 0; dupbad = 0; vcount = 0;
  endtask

  task automatic fill_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic run_load(input logic [15:0] seg, input logic [15:0] ip, input logic [15:0] cs,
                          input logic [15:0] len, input int nsend, input int dly,
                          input bit drop_wr, input bit bad_chk);
    logic [7:0] f[$];
    logic [7:0] sum = 8'd0;
    int nw;
    bit ok;
    f.push_back(seg[7:0]); f.push_back(seg[15:8]);
    f.push_back(ip[7:0]);  f.push_back(ip[15:8]);
    f.push_back(cs[7:0]);  f.push_back(cs[15:8]);
    f.push_back(len[7:0]); f.push_back(len[15:8]);
    for (int i = 0; i < nsend; i++) begin
      f.push_back(pay[i]);
      sum = sum + pay[i];
    end
    if (nsend >= int'(len) && !drop_wr) begin
      if (CHK) f.push_back((8'd0 - sum) ^ (bad_chk ? 8'h5A : 8'h00));
      f.push_back(8'($urandom));
      f.push_back(8'($urandom));
    end
    ack_delay = dly;
    clear_logs();
    ioctl_index = 16'd4; ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    for (int i = 0; i < f.size(); i++) begin
      if (drop_wr && i == f.size() - 1) begin
        strobe(i, f[i]);
        ioctl_download = 1'b0;
        wait_ready();
      end else send_byte(i, f[i]);
      if (i == 7) begin
        chk("hold_loading", 32'(cpu_hold), 1);
        chk("err_cleared", 32'(load_err), 0);
      end
    end
    ioctl_download = 1'b0;
    repeat (6) @(posedge clk_sys);
    #1;
    nw = (nsend < int'(len)) ? nsend : int'(len);
    ok = (nsend >= int'(len)) && !drop_wr && !(CHK && bad_chk);
    chk("n_writes", wq_addr.size(), nw);
    for (int i = 0; i < nw && i < wq_addr.size(); i++) begin
      chk("wr_addr", wq_addr[i], ((int'(seg) * 16) + i) % (1 << 20));
      chk("wr_data", wq_data[i], pay[i]);
      chk("wr_cycles", wq_cyc[i], dly);
    end
    chk("wait_tracks_wr", waitbad, 0);
    chk("wr_stable", unstable, 0);
    chk("wr_after_ack", dupbad, 0);
    chk("valid_pulses", vcount, 32'(ok));
    if (ok) begin
      chk("entry_cs", vcs, cs);
      chk("entry_ip", vip, ip);
      chk("hold_drop_same_cycle", vhold, 0);
      chk("hold_before_valid", vprev, 1);
    end
    chk("load_err", 32'(load_err), 32'(!ok));
    chk("cpu_hold", 32'(cpu_hold), 32'(!ok));
  endtask

  initial begin
    int n;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_hold", 32'(cpu_hold), 0);
    chk("rst_valid", 32'(entry_valid), 0);
    chk("rst_err", 32'(load_err), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_entry", {entry_cs, entry_ip}, 0);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    pay = '{8'hAA, 8'hBB, 8'hCC};
    run_load(16'h1000, 16'h0100, 16'h1000, 16'd3, 3, 1, 1'b0, 1'b0);
    run_load(16'h1000, 16'h0100, 16'h1000, 16'd3, 3, 5, 1'b0, 1'b0);
    fill_pay(32);
    run_load(16'hFFFF, 16'h1234, 16'h5678, 16'h0020, 32, 1, 1'b0, 1'b0);
    fill_pay(10);
    run_load(16'h2000, 16'h0000, 16'h2000, 16'd10, 5, 2, 1'b0, 1'b0);
    fill_pay(8);
    run_load(16'h0800, 16'h0042, 16'h0800, 16'd8, 8, 3, 1'b0, 1'b0);
    fill_pay(6);
    run_load(16'h0300, 16'h0001, 16'h0300, 16'd6, 3, 5, 1'b1, 1'b0);

    clear_logs();
    run_load(16'h0100, 16'h0010, 16'h0100, 16'd0, 0, 1, 1'b0, 1'b0);
    clear_logs();
    ioctl_index = 16'd5; ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    for (int i = 0; i < 12; i++) send_byte(i, 8'($urandom));
    ioctl_download = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("idx_mismatch_writes", wq_addr.size(), 0);
    chk("idx_mismatch_hold", 32'(cpu_hold), 0);
    chk("idx_mismatch_valid", vcount, 0);

    fill_pay(5);
    run_load(16'h4000, 16'h0200, 16'h4000, 16'd5, 5, 2, 1'b0, 1'b1);
    fill_pay(5);
    run_load(16'h4000, 16'h0200, 16'h4000, 16'd5, 5, 1, 1'b0, 1'b0);

    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 24);
      fill_pay(n);
      run_load(16'($urandom), 16'($urandom), 16'($urandom), 16'(n), n,
               $urandom_range(1, 4), 1'b0, 1'b0);
    end

    fill_pay(4);
    ack_delay = 1000;
    clear_logs();
    ioctl_index = 16'd4; ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    for (int i = 0; i < 8; i++) send_byte(i, (i == 6) ? 8'd4 : 8'h00);
    strobe(8, pay[0]);
    n = 0;
    while (!mem_wr && n < 20) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk("rst_wr_pending", 32'(mem_wr), 1);
    @(negedge clk_sys); #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_mem_wr", 32'(mem_wr), 0);
    chk("async_rst_wait", 32'(ioctl_wait), 0);
    chk("async_rst_hold", 32'(cpu_hold), 0);
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    chk("rst_abandon_writes", wq_addr.size(), 0);
    @(posedge clk_sys); #1;
    fill_pay(7);
    run_load(16'h0500, 16'h0777, 16'h0505, 16'd7, 7, 2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
